// File: rtl/note_spawner_if.sv
// Spawn-request handshake between the note spawner (master) and the note buffer (slave).
interface note_spawner_if;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_lane,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        output spawn_ready
    );
endinterface

// File: rtl/note_spawner.sv
// Turns a latched one-hot difficulty into a paced stream of spawn requests with
// pseudo-random lanes, then holds done once the whole note quota has been accepted.
module note_spawner #(
    parameter int unsigned BASE_PERIOD = 1000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     level,
    input  logic           level_valid,
    note_spawner_if.master spawn,
    output logic [2:0]     speed,
    output logic [4:0]     remaining,
    output logic           done,
    output logic           error
);

    localparam int CW = $clog2(BASE_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OFFER,
        S_DONE,
        S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic            valid_q, valid_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      speed_q, speed_d;
    logic [4:0]      rem_q, rem_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    // Counter reload value: one less than the spawn interval for this speed.
    function automatic logic [CW-1:0] interval_m1(input logic [2:0] spd);
        case (spd)
            3'd2:    return CW'(BASE_PERIOD / 2 - 1);
            3'd4:    return CW'(BASE_PERIOD / 4 - 1);
            default: return CW'(BASE_PERIOD - 1);
        endcase
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            valid_q <= 1'b0;
            lane_q  <= 2'd0;
            speed_q <= 3'd0;
            rem_q   <= 5'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
            speed_q <= speed_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        valid_d = valid_q;
        lane_d  = lane_q;
        speed_d = speed_q;
        rem_d   = rem_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (level_valid) begin
                    case (level)
                        3'b001: begin
                            speed_d = 3'd1;
                            rem_d   = 5'd8;
                            cnt_d   = interval_m1(3'd1);
                            state_d = S_WAIT;
                        end
                        3'b010: begin
                            speed_d = 3'd2;
                            rem_d   = 5'd12;
                            cnt_d   = interval_m1(3'd2);
                            state_d = S_WAIT;
                        end
                        3'b100: begin
                            speed_d = 3'd4;
                            rem_d   = 5'd16;
                            cnt_d   = interval_m1(3'd4);
                            state_d = S_WAIT;
                        end
                        default: begin
                            error_d = 1'b1;
                            state_d = S_ERR;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    valid_d = 1'b1;
                    lane_d  = lfsr_q[1:0];
                    state_d = S_OFFER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OFFER: begin
                // Request and lane stay frozen until the buffer takes them.
                if (spawn.spawn_ready) begin
                    valid_d = 1'b0;
                    lane_d  = 2'd0;
                    rem_d   = rem_q - 5'd1;
                    lfsr_d  = lfsr_next(lfsr_q);
                    if (rem_q == 5'd1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = interval_m1(speed_q);
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_lane  = lane_q;
    assign speed             = speed_q;
    assign remaining         = rem_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule
